// File: rtl/toggle_ramp_gen.sv
// Staggered switching-activity generator: NUM_CH delayed toggle lanes with a sequenced active-lane count.
// Optional TOGGLE_RAMP_LFSR_EN replaces the square-wave source with a rate-gated 16-bit LFSR.
module toggle_ramp_gen #(
    parameter int NUM_CH = 64,
    parameter int CNT_W  = 16,
    parameter int SEL_W  = 4,
    parameter int LEN_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [1:0]                     mode,
    input  logic [SEL_W-1:0]               rate_sel,
    input  logic [LEN_W-1:0]               step_len,
    input  logic [LEN_W-1:0]               burst_off,
    input  logic [LEN_W-1:0]               run_len,
    output logic [NUM_CH-1:0]              toggle_o,
    output logic [$clog2(NUM_CH+1)-1:0]    active_cnt,
    output logic                           busy,
    output logic                           done,
    output logic                           sig_o,
    output logic                           dbg_state
);

    localparam int AW = $clog2(NUM_CH + 1);
    localparam logic [AW-1:0] FULL = AW'(NUM_CH);
    localparam logic [AW-1:0] ONE  = AW'(1);
    localparam logic [1:0] M_STATIC = 2'b00;
    localparam logic [1:0] M_UP     = 2'b01;
    localparam logic [1:0] M_DOWN   = 2'b10;
    localparam logic [1:0] M_BURST  = 2'b11;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Handshake: start is a level request accepted only in IDLE (abort wins);
    // busy is high for every RUN cycle; done pulses one cycle on normal completion.

    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] x);
        return (x == '0) ? LEN_W'(1) : x;
    endfunction

    state_t            state, state_d;
    logic [1:0]        mode_q;
    logic [SEL_W-1:0]  sel_q;
    logic [LEN_W-1:0]  step_q, off_q, run_q;
    logic [LEN_W-1:0]  el, el_d, st, st_d, ph_len;
    logic              phase, phase_d;
    logic [AW-1:0]     active_d;
    logic              done_d, load, fin;
    logic [CNT_W-1:0]  cnt;
    logic              rate_bit, src;
    logic [NUM_CH-1:0] stage;

    assign busy      = (state == RUN);
    assign dbg_state = state;
    assign rate_bit  = |(cnt & (CNT_W'(1) << sel_q));
    assign ph_len    = phase ? step_q : off_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            active_cnt <= '0;
            done       <= 1'b0;
            el         <= '0;
            st         <= '0;
            phase      <= 1'b0;
            mode_q     <= '0;
            sel_q      <= '0;
            step_q     <= '0;
            off_q      <= '0;
            run_q      <= '0;
        end else begin
            state      <= state_d;
            active_cnt <= active_d;
            done       <= done_d;
            el         <= el_d;
            st         <= st_d;
            phase      <= phase_d;
            if (load) begin
                mode_q <= mode;
                sel_q  <= (int'(rate_sel) >= CNT_W) ? SEL_W'(CNT_W - 1) : rate_sel;
                step_q <= eff_len(step_len);
                off_q  <= eff_len(burst_off);
                run_q  <= eff_len(run_len);
            end
        end
    end

    always_comb begin
        state_d  = state;
        active_d = active_cnt;
        done_d   = 1'b0;
        el_d     = el;
        st_d     = st;
        phase_d  = phase;
        load     = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = RUN;
                    load     = 1'b1;
                    el_d     = '0;
                    st_d     = '0;
                    phase_d  = 1'b1;
                    active_d = (mode == M_UP) ? ONE : FULL;
                end
            end
            RUN: begin
                el_d = el + LEN_W'(1);
                if (abort) begin
                    state_d  = IDLE;
                    active_d = '0;
                end else begin
                    case (mode_q)
                        M_STATIC: fin = (el >= run_q - LEN_W'(1));
                        M_UP, M_DOWN: begin
                            if (st >= step_q - LEN_W'(1)) begin
                                st_d = '0;
                                if (mode_q == M_UP) begin
                                    if (active_cnt == FULL) fin = 1'b1;
                                    else active_d = active_cnt + ONE;
                                end else begin
                                    if (active_cnt == ONE) fin = 1'b1;
                                    else active_d = active_cnt - ONE;
                                end
                            end else begin
                                st_d = st + LEN_W'(1);
                            end
                        end
                        default: begin
                            // Total run length ends the burst even in the middle of an ON phase.
                            if (el >= run_q - LEN_W'(1)) begin
                                fin = 1'b1;
                            end else if (st >= ph_len - LEN_W'(1)) begin
                                st_d     = '0;
                                phase_d  = !phase;
                                active_d = phase ? '0 : FULL;
                            end else begin
                                st_d = st + LEN_W'(1);
                            end
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            state_d  = IDLE;
            active_d = '0;
            done_d   = 1'b1;
        end
    end

`ifdef TOGGLE_RAMP_LFSR_EN
    logic [15:0] lfsr;
    logic        bit_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr     <= 16'hACE1;
            bit_prev <= 1'b0;
        end else begin
            bit_prev <= rate_bit;
            if (rate_bit && !bit_prev) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign src = lfsr[0];
`else
    assign src = rate_bit;
`endif

    // The chain keeps running while idle so lanes are already staggered when a run starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            stage    <= '0;
            toggle_o <= '0;
            sig_o    <= 1'b0;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            stage <= {stage[NUM_CH-2:0], src};
            for (int k = 0; k < NUM_CH; k++) begin
                toggle_o[k] <= stage[k] & (k < int'(active_cnt));
            end
            sig_o <= ^toggle_o;
        end
    end

endmodule

// File: tb/tb_toggle_ramp_gen.sv
// Bench for toggle_ramp_gen: run-profile table, hand-written abort/reset sequences and random runs
// checked every cycle against a profile-queue / source-history reference model.
module tb_toggle_ramp_gen;
  localparam int N  = 64;
  localparam int CW = 8;
  localparam int SW = 4;
  localparam int LW = 16;
  localparam int AW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [1:0]    mode;
  logic [SW-1:0] rate_sel;
  logic [LW-1:0] step_len, burst_off, run_len;
  logic [N-1:0]  toggle_o;
  logic [AW-1:0] active_cnt;
  logic          busy, done, sig_o, dbg_state;

  int checks = 0;
  int errors = 0;

  toggle_ramp_gen #(.NUM_CH(N), .CNT_W(CW), .SEL_W(SW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .rate_sel(rate_sel), .step_len(step_len), .burst_off(burst_off), .run_len(run_len),
    .toggle_o(toggle_o), .active_cnt(active_cnt), .busy(busy), .done(done),
    .sig_o(sig_o), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model: expected active-count profile of the current run plus source history
  logic [AW-1:0] exp_q[$];
  bit            src_q[$];
  int unsigned   m_cnt;
  int            m_sel, m_active;
  bit            m_busy, m_done, m_sig, m_prev;
  logic [N-1:0]  m_tog;
  logic [15:0]   m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    // taps of x^16+x^14+x^13+x^11+1 counted from the output end
    return {s[16-16] ^ s[16-14] ^ s[16-13] ^ s[16-11], s[15:1]};
  endfunction

  function automatic bit cur_src();
`ifdef TOGGLE_RAMP_LFSR_EN
    return m_lfsr[0];
`else
    return bit'((m_cnt >> m_sel) & 1);
`endif
  endfunction

  function automatic int eff(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_sel = 0; m_active = 0;
    m_busy = 0; m_done = 0; m_sig = 0; m_prev = 0;
    m_tog = '0; m_lfsr = 16'hACE1;
    exp_q.delete();
    src_q.delete();
    src_q.push_front(cur_src());
  endtask

  task automatic build_profile();
    int s, o, r;
    s = eff(int'(step_len)); o = eff(int'(burst_off)); r = eff(int'(run_len));
    exp_q.delete();
    case (mode)
      2'b00: for (int i = 0; i < r; i++) exp_q.push_back(AW'(N));
      2'b01: for (int a = 1; a <= N; a++) for (int j = 0; j < s; j++) exp_q.push_back(AW'(a));
      2'b10: for (int a = N; a >= 1; a--) for (int j = 0; j < s; j++) exp_q.push_back(AW'(a));
      default: for (int i = 0; i < r; i++) exp_q.push_back(((i % (s + o)) < s) ? AW'(N) : AW'(0));
    endcase
  endtask

  task automatic model_advance();
    logic [N-1:0] nt;
    bit b;
    int new_sel;
    b = bit'((m_cnt >> m_sel) & 1);
    new_sel = m_sel;
    for (int k = 0; k < N; k++) nt[k] = (k + 1 < src_q.size() && k < m_active) ? src_q[k+1] : 1'b0;
    m_sig = ^m_tog;
    m_tog = nt;
    m_done = 0;
    if (m_busy) begin
      if (abort) begin
        m_busy = 0; m_active = 0; exp_q.delete();
      end else if (exp_q.size() == 0) begin
        m_busy = 0; m_active = 0; m_done = 1;
      end else begin
        m_active = int'(exp_q.pop_front());
      end
    end else if (start && !abort) begin
      build_profile();
      m_busy = 1;
      m_active = int'(exp_q.pop_front());
      new_sel = (int'(rate_sel) >= CW) ? CW - 1 : int'(rate_sel);
    end
    if (b && !m_prev) m_lfsr = lfsr_step(m_lfsr);
    m_prev = b;
    m_cnt = (m_cnt + 1) % (1 << CW);
    m_sel = new_sel;
    src_q.push_front(cur_src());
    if (src_q.size() > N + 2) void'(src_q.pop_back());
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("active_cnt", 64'(active_cnt), 64'(m_active));
    chk("toggle_o", 64'(toggle_o), 64'(m_tog));
    chk("sig_o", 64'(sig_o), 64'(m_sig));
    chk("dbg_state", 64'(dbg_state), 64'(m_busy));
  endtask

  // driver: inputs are stable here, model steps, then DUT sampled on the falling edge
  task automatic cycle();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_run(input logic [1:0] md, input int sel, input int s, input int o, input int r);
    mode = md; rate_sel = SW'(sel); step_len = LW'(s); burst_off = LW'(o); run_len = LW'(r);
  endtask

  typedef struct {
    logic [1:0] md;
    int sel, s, o, r;
    int exp_busy;
    int exp_full;
  } vec_t;

  vec_t vt[7];

  initial begin
    int busy_n, full_n;
    bit finished;

    vt[0] = '{2'b00, 0,  1,  1, 100, 100, 100};
    vt[1] = '{2'b01, 1,  4,  1,   1, 256,   4};
    vt[2] = '{2'b11, 2, 10,  5,  32,  32,  22};
    vt[3] = '{2'b10, 3,  3,  1,   1, 192,   3};
    vt[4] = '{2'b01, 15, 0,  1,   1,  64,   1};
    vt[5] = '{2'b00, 5,  1,  1,   0,   1,   1};
    vt[6] = '{2'b11, 0,  0,  0,   5,   5,   3};

    rst = 1'b0; start = 1'b0; abort = 1'b0;
    set_run(2'b00, 0, 1, 1, 1);

    // reset held with a toggling start request
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = ~start;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_toggle", 64'(toggle_o), 64'd0);
      chk("rst_active", 64'(active_cnt), 64'd0);
      chk("rst_done_sig", 64'({done, sig_o}), 64'd0);
    end
    @(negedge clk);
    start = 1'b0;
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // table of run profiles
    for (int v = 0; v < 7; v++) begin
      set_run(vt[v].md, vt[v].sel, vt[v].s, vt[v].o, vt[v].r);
      start = 1'b1;
      cycle();
      start = 1'b0;
      busy_n = 0; full_n = 0; finished = 0;
      for (int i = 0; i < 2000 && !finished; i++) begin
        if (busy) busy_n++;
        if (busy && active_cnt == AW'(N)) full_n++;
        if (done) finished = 1;
        else cycle();
      end
      chk($sformatf("vec%0d_finished", v), 64'(finished), 64'd1);
      chk($sformatf("vec%0d_busy_cycles", v), 64'(busy_n), 64'(vt[v].exp_busy));
      chk($sformatf("vec%0d_full_cycles", v), 64'(full_n), 64'(vt[v].exp_full));
      cycle();
      chk($sformatf("vec%0d_done_once", v), 64'(done), 64'd0);
      for (int i = 0; i < 3; i++) cycle();
    end

    // ramp-down aborted after 20 run cycles, then start+abort together in IDLE
    set_run(2'b10, 2, 3, 1, 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 19; i++) cycle();
    chk("abort_pre_busy", 64'(busy), 64'd1);
    chk("abort_pre_active", 64'(active_cnt), 64'd58);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_active", 64'(active_cnt), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("abort_no_done", 64'(done), 64'd0);
    end
    start = 1'b1; abort = 1'b1;
    cycle();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 64'(busy), 64'd0);
    cycle();

    // asynchronous reset in the middle of a run
    set_run(2'b00, 1, 1, 1, 50);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_active", 64'(active_cnt), 64'd0);
    chk("arst_toggle", 64'(toggle_o), 64'd0);
    chk("arst_done_sig", 64'({done, sig_o}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // random runs with stray start requests and occasional aborts
    for (int t = 0; t < 40; t++) begin
      set_run(2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 4), $urandom_range(0, 40));
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 300; i++) begin
        start = ($urandom_range(0, 9) == 0);
        abort = ($urandom_range(0, 99) == 0);
        cycle();
        if (!m_busy) break;
      end
      start = 1'b0; abort = 1'b0;
      for (int i = 0; i < $urandom_range(1, 4); i++) cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
